// File: rtl/reg_pw_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_pw_fifo_reader
// Purpose  : Byte-wise USB register readout of a FWFT capture FIFO through a
//            one-word holding register, with flush, sticky status and counter.
// Revision : 1.0 - initial release
// ============================================================================
module reg_pw_fifo_reader #(
   parameter int         pDATA_WIDTH  = 18,
   parameter int         pCOUNT_WIDTH = 16,
   parameter logic [5:0] pADDR_DATA   = 6'd20,
   parameter logic [5:0] pADDR_STAT   = 6'd21,
   parameter logic [5:0] pADDR_CTRL   = 6'd22,
   parameter logic [5:0] pADDR_CNT    = 6'd23
) (
   input  logic                   cwusb_clk,
   input  logic                   reset_n,
   input  logic [5:0]             reg_address,
   input  logic [15:0]            reg_bytecnt,
   input  logic                   reg_addrvalid,
   input  logic                   reg_read,
   input  logic                   reg_write,
   input  logic [7:0]             write_data,
   output logic [7:0]             read_data,
   input  logic                   arm_i,
   output logic                   arm_o,
   input  logic [pDATA_WIDTH-1:0] fifo_dout,
   input  logic                   fifo_empty,
   input  logic                   fifo_overflow,
   output logic                   fifo_rd_en,
   output logic                   flushing
);

   localparam int c_WORD_BYTES = (pDATA_WIDTH + 7) / 8;
   localparam int c_HOLD_WIDTH = c_WORD_BYTES * 8;
   localparam int c_PTR_WIDTH  = (c_WORD_BYTES > 1) ? $clog2(c_WORD_BYTES) : 1;
   localparam logic [c_PTR_WIDTH-1:0] c_PTR_LAST = c_PTR_WIDTH'(c_WORD_BYTES - 1);
   localparam int c_CNT_BYTES  = (pCOUNT_WIDTH + 7) / 8;
   localparam int c_CNT_PAD    = c_CNT_BYTES * 8;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_READY = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_HOLD_WIDTH-1:0] r_hold;
   logic [c_PTR_WIDTH-1:0]  r_ptr;
   logic [pCOUNT_WIDTH-1:0] r_count;
   logic                    r_underflow;
   logic                    r_overflow;
   logic                    r_arm_d;
   logic [7:0]              r_read_data;

   logic                    w_rd_access;
   logic                    w_data_rd;
   logic                    w_hold_valid;
   logic                    w_consume;
   logic                    w_flush_req;
   logic                    w_stat_wr;
   logic                    w_cnt_wr;
   logic                    w_pop;
   logic [7:0]              w_hold_byte;
   logic [7:0]              w_count_byte;
   logic [c_CNT_PAD-1:0]    w_count_pad;
   logic                    w_unused_wdata;

   assign w_rd_access  = reg_addrvalid & reg_read;
   assign w_data_rd    = w_rd_access & (reg_address == pADDR_DATA);
   assign w_hold_valid = (r_state == S_READY);
   assign w_consume    = w_data_rd & w_hold_valid & (r_ptr == c_PTR_LAST);
   assign w_stat_wr    = reg_addrvalid & reg_write & (reg_address == pADDR_STAT);
   assign w_cnt_wr     = reg_addrvalid & reg_write & (reg_address == pADDR_CNT);
   // A request arriving while already flushing is dropped
   assign w_flush_req  = (r_state != S_FLUSH) &
                         ((arm_i & ~r_arm_d) |
                          (reg_addrvalid & reg_write & (reg_address == pADDR_CTRL) & write_data[0]));
   assign w_unused_wdata = ^{write_data[7:5], write_data[2:1]};

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_FILL: begin
            w_pop = ~fifo_empty;
            if (!fifo_empty) w_state_nxt = S_READY;
         end
         S_READY: begin
            w_pop = w_consume & ~fifo_empty;
            if (w_consume && fifo_empty) w_state_nxt = S_FILL;
         end
         S_FLUSH: begin
            w_pop = ~fifo_empty;
            if (fifo_empty) w_state_nxt = S_FILL;
         end
         default: w_state_nxt = S_FILL;
      endcase
      if (w_flush_req) w_state_nxt = S_FLUSH;
   end

   // Gated with reset so the FIFO is never popped while the block is held in reset
   assign fifo_rd_en = w_pop & reset_n;
   assign flushing   = (r_state == S_FLUSH);
   assign arm_o      = arm_i & ~flushing & reset_n;
   assign read_data  = r_read_data;

   always_comb begin
      w_hold_byte = 8'h00;
      for (int i = 0; i < c_WORD_BYTES; i++) begin
         if (r_ptr == c_PTR_WIDTH'(i)) w_hold_byte = r_hold[i*8 +: 8];
      end
   end

   always_comb begin
      w_count_pad  = c_CNT_PAD'(r_count);
      w_count_byte = 8'h00;
      for (int i = 0; i < c_CNT_BYTES; i++) begin
         if (reg_bytecnt == 16'(i)) w_count_byte = w_count_pad[i*8 +: 8];
      end
   end

   always_ff @(posedge cwusb_clk) begin
      if (!reset_n) begin
         r_state <= S_FILL;
         r_hold  <= '0;
         r_arm_d <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_arm_d <= arm_i;
         if (w_pop) r_hold <= c_HOLD_WIDTH'(fifo_dout);
      end
   end

   always_ff @(posedge cwusb_clk) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (w_flush_req || !reg_addrvalid) begin
         r_ptr <= '0;
      end else if (w_data_rd && w_hold_valid) begin
         r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTR_WIDTH'(1);
      end
   end

   always_ff @(posedge cwusb_clk) begin
      if (!reset_n) begin
         r_read_data <= 8'h00;
      end else begin
         r_read_data <= 8'h00;
         if (w_rd_access) begin
            case (reg_address)
               pADDR_DATA: r_read_data <= w_hold_valid ? w_hold_byte : 8'h00;
               pADDR_STAT: r_read_data <= {3'b000, r_overflow, r_underflow,
                                           flushing, fifo_empty, w_hold_valid};
               pADDR_CNT:  r_read_data <= w_count_byte;
               default:    r_read_data <= 8'h00;
            endcase
         end
      end
   end

   // Set has priority over a clear arriving in the same cycle
   always_ff @(posedge cwusb_clk) begin
      if (!reset_n) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_data_rd && r_state == S_FILL) r_underflow <= 1'b1;
         else if (w_stat_wr && write_data[3]) r_underflow <= 1'b0;
         if (fifo_overflow) r_overflow <= 1'b1;
         else if (w_stat_wr && write_data[4]) r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge cwusb_clk) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (w_cnt_wr) begin
         r_count <= '0;
      end else if (w_consume && (r_count != '1)) begin
         r_count <= r_count + pCOUNT_WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_pw_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_pw_fifo_reader
// Purpose  : Directed scoreboard bench for reg_pw_fifo_reader (18-bit words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pw_fifo_reader;

   localparam int         c_DW     = 18;
   localparam int         c_CW     = 12;
   localparam logic [5:0] c_A_DATA = 6'd20;
   localparam logic [5:0] c_A_STAT = 6'd21;
   localparam logic [5:0] c_A_CTRL = 6'd22;
   localparam logic [5:0] c_A_CNT  = 6'd23;

   logic            cwusb_clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [5:0]      reg_address = 6'd0;
   logic [15:0]     reg_bytecnt = 16'd0;
   logic            reg_addrvalid = 1'b0;
   logic            reg_read = 1'b0;
   logic            reg_write = 1'b0;
   logic [7:0]      write_data = 8'h00;
   logic [7:0]      read_data;
   logic            arm_i = 1'b0;
   logic            arm_o;
   logic [c_DW-1:0] fifo_dout = '0;
   logic            fifo_empty = 1'b1;
   logic            fifo_overflow = 1'b0;
   logic            fifo_rd_en;
   logic            flushing;

   logic [c_DW-1:0] fifo_q[$];
   logic [7:0]      exp_q[$];
   string           name_q[$];
   int              n_cmp = 0;
   int              n_bad = 0;

   reg_pw_fifo_reader #(.pDATA_WIDTH(c_DW), .pCOUNT_WIDTH(c_CW)) u_dut (
      .cwusb_clk    (cwusb_clk),
      .reset_n      (reset_n),
      .reg_address  (reg_address),
      .reg_bytecnt  (reg_bytecnt),
      .reg_addrvalid(reg_addrvalid),
      .reg_read     (reg_read),
      .reg_write    (reg_write),
      .write_data   (write_data),
      .read_data    (read_data),
      .arm_i        (arm_i),
      .arm_o        (arm_o),
      .fifo_dout    (fifo_dout),
      .fifo_empty   (fifo_empty),
      .fifo_overflow(fifo_overflow),
      .fifo_rd_en   (fifo_rd_en),
      .flushing     (flushing)
   );

   always #5 cwusb_clk = ~cwusb_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [17:0] w, input int b);
      case (b)
         0:       return w[7:0];
         1:       return w[15:8];
         default: return {6'b000000, w[17:16]};
      endcase
   endfunction

   function automatic logic [17:0] bulk_word(input int k);
      return 18'((k * 755) ^ 18'h15A5A);
   endfunction

   // FWFT FIFO model: pushes appear at the next edge, pops on fifo_rd_en
   initial forever begin
      @(posedge cwusb_clk);
      if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
      if (fifo_q.size() > 0) fifo_dout <= fifo_q[0];
      else fifo_dout <= '0;
   end

   // Monitor: any read accepted at an edge is answered on read_data after the next edge
   initial begin
      logic       pend;
      logic [7:0] e;
      string      nm;
      forever begin
         @(posedge cwusb_clk);
         pend = reset_n & reg_addrvalid & reg_read;
         @(negedge cwusb_clk);
         if (fifo_rd_en) check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
         if (pend) begin
            if (exp_q.size() == 0) begin
               check("unexpected_read", exp_q.size(), 32'd1);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check(nm, {24'd0, read_data}, {24'd0, e});
            end
         end
      end
   end

   task automatic cyc();
      @(posedge cwusb_clk);
      #1;
   endtask

   task automatic idle(input int n);
      reg_addrvalid = 1'b0;
      reg_read      = 1'b0;
      reg_write     = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] e, input string nm);
      reg_addrvalid = 1'b1;
      reg_read      = 1'b1;
      reg_write     = 1'b0;
      reg_address   = a;
      reg_bytecnt   = bc;
      exp_q.push_back(e);
      name_q.push_back(nm);
      cyc();
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      reg_addrvalid = 1'b1;
      reg_read      = 1'b0;
      reg_write     = 1'b1;
      reg_address   = a;
      write_data    = d;
      cyc();
      reg_addrvalid = 1'b0;
      reg_write     = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_rd, arm_hi, seen, done;
      logic [17:0] w;

      // Reset state
      cyc(); cyc(); cyc();
      check("rst_read_data", {24'd0, read_data}, 32'd0);
      check("rst_flushing", {31'd0, flushing}, 32'd0);
      check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("rst_arm_o", {31'd0, arm_o}, 32'd0);
      reset_n = 1'b1;
      idle(2);
      rd(c_A_STAT, 16'd0, 8'h02, "rst_stat");
      rd(c_A_CNT, 16'd0, 8'h00, "rst_cnt");
      idle(1);

      // Two-word burst, no bubble between words
      fifo_q.push_back(18'h2A55B);
      fifo_q.push_back(18'h01234);
      idle(4);
      rd(c_A_DATA, 16'd0, 8'h5B, "t1_b0");
      rd(c_A_DATA, 16'd0, 8'hA5, "t1_b1");
      rd(c_A_DATA, 16'd0, 8'h02, "t1_b2");
      rd(c_A_DATA, 16'd0, 8'h34, "t1_b3");
      rd(c_A_DATA, 16'd0, 8'h12, "t1_b4");
      rd(c_A_DATA, 16'd0, 8'h00, "t1_b5");
      idle(1);
      rd(c_A_CNT, 16'd0, 8'h02, "t1_cnt0");
      rd(c_A_CNT, 16'd1, 8'h00, "t1_cnt1");
      idle(1);
      rd(c_A_STAT, 16'd0, 8'h02, "t1_stat");
      idle(1);

      // Underflow and sticky handling
      rd(c_A_DATA, 16'd0, 8'h00, "t2_underflow_data");
      idle(1);
      rd(c_A_STAT, 16'd0, 8'h0A, "t2_stat_udf");
      idle(1);
      wr(c_A_STAT, 8'h08);
      rd(c_A_STAT, 16'd0, 8'h02, "t2_stat_udf_clr");
      idle(1);
      fifo_overflow = 1'b1;
      cyc();
      fifo_overflow = 1'b0;
      rd(c_A_STAT, 16'd0, 8'h12, "t2_stat_ovf");
      idle(1);
      fifo_overflow = 1'b1;
      wr(c_A_STAT, 8'h10);
      fifo_overflow = 1'b0;
      rd(c_A_STAT, 16'd0, 8'h12, "t2_ovf_set_beats_clr");
      idle(1);
      wr(c_A_STAT, 8'h10);
      rd(c_A_STAT, 16'd0, 8'h02, "t2_stat_ovf_clr");
      idle(1);

      // Flush on arm rising edge
      for (int k = 1; k <= 5; k++) fifo_q.push_back(18'(k));
      idle(4);
      rd(c_A_STAT, 16'd0, 8'h01, "t3_stat_pre");
      idle(1);
      arm_i = 1'b1;
      @(posedge cwusb_clk);
      n_rd = 0; arm_hi = 0; seen = 0; done = 0;
      for (int i = 0; i < 20 && done == 0; i++) begin
         @(negedge cwusb_clk);
         if (flushing) begin
            seen++;
            if (fifo_rd_en) n_rd++;
            if (arm_o) arm_hi++;
         end else begin
            done = 1;
         end
      end
      check("t3_flush_ended", done, 32'd1);
      check("t3_flush_cycles", seen, 32'd5);
      check("t3_rd_en_cycles", n_rd, 32'd4);
      check("t3_arm_o_in_flush", arm_hi, 32'd0);
      check("t3_arm_o_after", {31'd0, arm_o}, 32'd1);
      cyc();
      arm_i = 1'b0;
      idle(2);

      // Flush on CTRL write; a read while flushing returns 0 and sets no sticky
      fifo_q.push_back(18'h3FFFF);
      fifo_q.push_back(18'h11111);
      fifo_q.push_back(18'h22222);
      idle(4);
      wr(c_A_CTRL, 8'h01);
      rd(c_A_DATA, 16'd0, 8'h00, "t3c_read_in_flush");
      idle(5);
      rd(c_A_STAT, 16'd0, 8'h02, "t3c_stat_after");
      idle(1);

      // Consume on an empty FIFO that fills in the same cycle
      fifo_q.push_back(18'h0ABCD);
      idle(4);
      rd(c_A_DATA, 16'd0, 8'hCD, "t4_w1_b0");
      rd(c_A_DATA, 16'd0, 8'hAB, "t4_w1_b1");
      fifo_q.push_back(18'h3C0F1);
      rd(c_A_DATA, 16'd0, 8'h00, "t4_w1_b2");
      idle(1);
      rd(c_A_DATA, 16'd0, 8'hF1, "t4_w2_b0");
      rd(c_A_DATA, 16'd0, 8'hC0, "t4_w2_b1");
      rd(c_A_DATA, 16'd0, 8'h03, "t4_w2_b2");
      idle(1);

      // Byte pointer returns to 0 when the address drops
      fifo_q.push_back(18'h12345);
      idle(4);
      rd(c_A_DATA, 16'd0, 8'h45, "ptr_b0");
      idle(1);
      rd(c_A_DATA, 16'd0, 8'h45, "ptr_b0_again");
      rd(c_A_DATA, 16'd0, 8'h23, "ptr_b1");
      rd(c_A_DATA, 16'd0, 8'h01, "ptr_b2");
      idle(1);
      rd(c_A_CNT, 16'd0, 8'h05, "cnt_five");
      idle(1);

      // Reset in the middle of a word
      fifo_q.push_back(18'h2BEEF);
      fifo_q.push_back(18'h1C3D2);
      idle(4);
      rd(c_A_DATA, 16'd0, 8'hEF, "t5_b0");
      idle(0);
      reg_addrvalid = 1'b0;
      reg_read      = 1'b0;
      reset_n = 1'b0;
      cyc(); cyc();
      check("t5_rst_read_data", {24'd0, read_data}, 32'd0);
      check("t5_rst_flushing", {31'd0, flushing}, 32'd0);
      check("t5_rst_rd_en_gated", {31'd0, fifo_rd_en}, 32'd0);
      reset_n = 1'b1;
      idle(3);
      rd(c_A_CNT, 16'd0, 8'h00, "t5_cnt_cleared");
      idle(1);
      rd(c_A_STAT, 16'd0, 8'h03, "t5_stat");
      idle(1);
      rd(c_A_DATA, 16'd0, 8'hD2, "t5_next_b0");
      rd(c_A_DATA, 16'd0, 8'hC3, "t5_next_b1");
      rd(c_A_DATA, 16'd0, 8'h01, "t5_next_b2");
      idle(1);
      rd(c_A_CNT, 16'd0, 8'h01, "t5_cnt_one");
      idle(1);

      // Counter saturation (12-bit counter instance)
      wr(c_A_CNT, 8'h00);
      for (int k = 0; k < 4096; k++) fifo_q.push_back(bulk_word(k));
      idle(4);
      for (int k = 0; k < 4094; k++) begin
         w = bulk_word(k);
         for (int b = 0; b < 3; b++) rd(c_A_DATA, 16'd0, byte_of(w, b), "bulk_byte");
      end
      idle(1);
      rd(c_A_CNT, 16'd0, 8'hFE, "t6_cnt_ffe_lo");
      rd(c_A_CNT, 16'd1, 8'h0F, "t6_cnt_ffe_hi");
      idle(1);
      w = bulk_word(4094);
      for (int b = 0; b < 3; b++) rd(c_A_DATA, 16'd0, byte_of(w, b), "bulk_byte");
      idle(1);
      rd(c_A_CNT, 16'd0, 8'hFF, "t6_cnt_sat_lo");
      rd(c_A_CNT, 16'd1, 8'h0F, "t6_cnt_sat_hi");
      idle(1);
      w = bulk_word(4095);
      for (int b = 0; b < 3; b++) rd(c_A_DATA, 16'd0, byte_of(w, b), "bulk_byte");
      idle(1);
      rd(c_A_CNT, 16'd0, 8'hFF, "t6_cnt_hold_lo");
      rd(c_A_CNT, 16'd1, 8'h0F, "t6_cnt_hold_hi");
      rd(c_A_CNT, 16'd2, 8'h00, "t6_cnt_beyond");
      idle(1);
      wr(c_A_CNT, 8'h5A);
      rd(c_A_CNT, 16'd0, 8'h00, "t6_cnt_clr_lo");
      rd(c_A_CNT, 16'd1, 8'h00, "t6_cnt_clr_hi");
      idle(3);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
